// File: rtl/mem_stage_if.sv
// Exe-to-mem handshake and operand bundle. The exe stage drives it through the
// master modport, and mem_stage consumes it through the slave modport.
interface mem_stage_if;
    logic        valid_ex;
    logic        ready_ex;
    logic [31:0] IR_ex;
    logic [31:0] NPC_ex;
    logic [31:0] ALU_res;
    logic [31:0] B_ex;
    logic        cond;

    modport master (
        output valid_ex,
        output IR_ex,
        output NPC_ex,
        output ALU_res,
        output B_ex,
        output cond,
        input  ready_ex
    );

    modport slave (
        input  valid_ex,
        input  IR_ex,
        input  NPC_ex,
        input  ALU_res,
        input  B_ex,
        input  cond,
        output ready_ex
    );
endinterface

// File: rtl/mem_stage.sv
// MIPS32 MEM stage: LW/SW on an internal word-addressed RAM with optional wait
// states, BEQZ/BNEQZ resolution, and registered results for write-back.
// Optional feature: define MEM_ALIGN_CHECK_EN to add the misalign output and
// suppress the RAM access for LW/SW whose byte offset is non-zero.
module mem_stage #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned MEM_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  ex,
    output logic        valid_mem,
    output logic [31:0] IR_mem,
    output logic [31:0] ALU_out_mem,
    output logic [31:0] LMD,
    output logic        branch_taken,
    output logic [31:0] branch_target
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        misalign
`endif
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [5:0] OP_LW    = 6'h30;
    localparam logic [5:0] OP_SW    = 6'h31;
    localparam logic [5:0] OP_BNEQZ = 6'h34;
    localparam logic [5:0] OP_BEQZ  = 6'h35;

    typedef enum logic {ST_IDLE, ST_WAIT} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] ir_l_q, ir_l_d, alu_l_q, alu_l_d, b_l_q, b_l_d, npc_l_q, npc_l_d;
    logic        ready_q, ready_d;
    logic        valid_mem_q, valid_mem_d;
    logic [31:0] ir_mem_q, ir_mem_d, alu_out_q, alu_out_d, lmd_q, lmd_d;
    logic        taken_q, taken_d;
    logic [31:0] target_q, target_d;
    logic        mis_q, mis_d;

    logic [31:0] ram_q [DEPTH];

    logic          in_wait, complete, c_cond, c_lw, c_sw, c_mis, ram_we;
    logic [31:0]   c_ir, c_alu, c_b, c_npc, rd_data;
    logic [5:0]    c_op;
    logic [AW-1:0] c_addr;

    // Operand select: latched copy while waiting, live exe outputs otherwise
    always_comb begin
        in_wait = (state_q == ST_WAIT);
        c_ir    = in_wait ? ir_l_q  : ex.IR_ex;
        c_alu   = in_wait ? alu_l_q : ex.ALU_res;
        c_b     = in_wait ? b_l_q   : ex.B_ex;
        c_npc   = in_wait ? npc_l_q : ex.NPC_ex;
        c_cond  = in_wait ? 1'b0    : ex.cond;
        c_op    = c_ir[31:26];
        c_lw    = (c_op == OP_LW);
        c_sw    = (c_op == OP_SW);
`ifdef MEM_ALIGN_CHECK_EN
        c_mis   = (c_lw || c_sw) && (c_alu[1:0] != 2'b00);
`else
        c_mis   = 1'b0;
`endif
        c_addr  = c_alu[AW+1:2];
        rd_data = ram_q[c_addr];
    end

    // Next-state, completion and output-register logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ir_l_d      = ir_l_q;
        alu_l_d     = alu_l_q;
        b_l_d       = b_l_q;
        npc_l_d     = npc_l_q;
        valid_mem_d = 1'b0;
        ir_mem_d    = ir_mem_q;
        alu_out_d   = alu_out_q;
        lmd_d       = lmd_q;
        taken_d     = 1'b0;
        target_d    = target_q;
        mis_d       = 1'b0;
        ram_we      = 1'b0;
        complete    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ex.valid_ex) begin
                    if ((c_lw || c_sw) && !c_mis && (MEM_LAT != 0)) begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(MEM_LAT);
                        ir_l_d  = ex.IR_ex;
                        alu_l_d = ex.ALU_res;
                        b_l_d   = ex.B_ex;
                        npc_l_d = ex.NPC_ex;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd1) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                    cnt_d    = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase

        if (complete) begin
            valid_mem_d = 1'b1;
            ir_mem_d    = c_ir;
            alu_out_d   = c_alu;
            taken_d     = ((c_op == OP_BNEQZ) && !c_cond) || ((c_op == OP_BEQZ) && c_cond);
            target_d    = taken_d ? c_alu : c_npc;
            mis_d       = c_mis;
            ram_we      = c_sw && !c_mis;
            if (c_lw && !c_mis) begin
                lmd_d = rd_data;
            end
        end

        ready_d = (state_d == ST_IDLE);
    end

    // Pipeline and FSM state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            ir_l_q      <= '0;
            alu_l_q     <= '0;
            b_l_q       <= '0;
            npc_l_q     <= '0;
            ready_q     <= 1'b1;
            valid_mem_q <= 1'b0;
            ir_mem_q    <= '0;
            alu_out_q   <= '0;
            lmd_q       <= '0;
            taken_q     <= 1'b0;
            target_q    <= '0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ir_l_q      <= ir_l_d;
            alu_l_q     <= alu_l_d;
            b_l_q       <= b_l_d;
            npc_l_q     <= npc_l_d;
            ready_q     <= ready_d;
            valid_mem_q <= valid_mem_d;
            ir_mem_q    <= ir_mem_d;
            alu_out_q   <= alu_out_d;
            lmd_q       <= lmd_d;
            taken_q     <= taken_d;
            target_q    <= target_d;
            mis_q       <= mis_d;
        end
    end

    // Data RAM write; contents survive reset, and a store cut short by reset is dropped
    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            ram_q[c_addr] <= c_b;
        end
    end

    assign ex.ready_ex     = ready_q;
    assign valid_mem       = valid_mem_q;
    assign IR_mem          = ir_mem_q;
    assign ALU_out_mem     = alu_out_q;
    assign LMD             = lmd_q;
    assign branch_taken    = taken_q;
    assign branch_target   = target_q;
`ifdef MEM_ALIGN_CHECK_EN
    assign misalign        = mis_q;
`else
    logic unused_mis;
    assign unused_mis      = mis_q;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage. Two instances share one stimulus stream: dut_a has
// MEM_LAT=2, dut_b has MEM_LAT=0. A transaction-level model predicts each one.
module tb_mem_stage;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned LAT_A = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        s_valid = 1'b0;
    logic        s_cond  = 1'b0;
    logic [31:0] s_ir = '0, s_npc = '0, s_alu = '0, s_b = '0;

    mem_stage_if ifa();
    mem_stage_if ifb();
    assign ifa.valid_ex = s_valid;
    assign ifa.IR_ex    = s_ir;
    assign ifa.NPC_ex   = s_npc;
    assign ifa.ALU_res  = s_alu;
    assign ifa.B_ex     = s_b;
    assign ifa.cond     = s_cond;
    assign ifb.valid_ex = s_valid;
    assign ifb.IR_ex    = s_ir;
    assign ifb.NPC_ex   = s_npc;
    assign ifb.ALU_res  = s_alu;
    assign ifb.B_ex     = s_b;
    assign ifb.cond     = s_cond;

    logic [1:0]       o_valid, o_taken, o_mis, o_ready;
    logic [1:0][31:0] o_ir, o_alu, o_lmd, o_tgt;
    assign o_ready[0] = ifa.ready_ex;
    assign o_ready[1] = ifb.ready_ex;
`ifndef MEM_ALIGN_CHECK_EN
    assign o_mis = '0;
`endif

    mem_stage #(.DEPTH(DEPTH), .MEM_LAT(LAT_A)) dut_a (
        .clk(clk), .rst(rst), .ex(ifa),
        .valid_mem(o_valid[0]), .IR_mem(o_ir[0]), .ALU_out_mem(o_alu[0]),
        .LMD(o_lmd[0]), .branch_taken(o_taken[0]), .branch_target(o_tgt[0])
`ifdef MEM_ALIGN_CHECK_EN
        , .misalign(o_mis[0])
`endif
    );

    mem_stage #(.DEPTH(DEPTH), .MEM_LAT(0)) dut_b (
        .clk(clk), .rst(rst), .ex(ifb),
        .valid_mem(o_valid[1]), .IR_mem(o_ir[1]), .ALU_out_mem(o_alu[1]),
        .LMD(o_lmd[1]), .branch_taken(o_taken[1]), .branch_target(o_tgt[1])
`ifdef MEM_ALIGN_CHECK_EN
        , .misalign(o_mis[1])
`endif
    );

    // ---------------- transaction model ----------------
    typedef struct {
        int          due;
        logic [31:0] ir, alu, lmd, tgt, old;
        bit          taken, lw_ok, sw_ok, mis;
        int          waddr;
    } pend_t;

    pend_t       pend [2];
    bit          pend_v [2];
    int          busy_until [2];
    logic [31:0] mram [2][DEPTH];

    bit          e_valid [2], e_taken [2], e_mis [2], e_ready [2];
    logic [31:0] e_ir [2], e_alu [2], e_lmd [2], e_tgt [2];

    int checks = 0, failures = 0;
    int cyc = 0;
    bit rst_edge = 1'b1;
    bit go = 1'b0;
    int last_acc = 0, last_due = 0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= rst;
    end

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d actual=%h required=%h", nm, d, cyc, act, exp);
        end
    endtask

    // Predict the outcome of one accepted instruction for instance d
    task automatic model_issue(input int d, input int acc, input logic [31:0] ir, npc, alu, b,
                               input logic cnd);
        pend_t      p;
        logic [5:0] op;
        bit         lw, sw, mis;
        int         lat, idx;
        op  = ir[31:26];
        lw  = (op == 6'h30);
        sw  = (op == 6'h31);
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = (lw || sw) && (alu[1:0] != 2'b00);
`endif
        lat = (d == 0) ? int'(LAT_A) : 0;
        if (!(lw || sw) || mis) lat = 0;
        idx     = int'((alu >> 2) % DEPTH);
        p.due   = acc + lat;
        p.ir    = ir;
        p.alu   = alu;
        p.taken = ((op == 6'h34) && !cnd) || ((op == 6'h35) && cnd);
        p.tgt   = p.taken ? alu : npc;
        p.lw_ok = lw && !mis;
        p.sw_ok = sw && !mis;
        p.mis   = mis;
        p.lmd   = mram[d][idx];
        p.old   = mram[d][idx];
        p.waddr = idx;
        if (p.sw_ok) mram[d][idx] = b;
        pend[d]       = p;
        pend_v[d]     = 1'b1;
        busy_until[d] = acc + lat;
    endtask

    // Per-cycle comparison of both instances against the model
    initial begin
        wait (go);
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst_edge) begin
                    if (pend_v[d] && pend[d].sw_ok) mram[d][pend[d].waddr] = pend[d].old;
                    pend_v[d] = 1'b0;
                    busy_until[d] = 0;
                    e_valid[d] = 0; e_taken[d] = 0; e_mis[d] = 0;
                    e_ir[d] = '0; e_alu[d] = '0; e_lmd[d] = '0; e_tgt[d] = '0;
                end else if (pend_v[d] && pend[d].due == cyc) begin
                    e_valid[d] = 1'b1;
                    e_ir[d]    = pend[d].ir;
                    e_alu[d]   = pend[d].alu;
                    e_taken[d] = pend[d].taken;
                    e_tgt[d]   = pend[d].tgt;
                    e_mis[d]   = pend[d].mis;
                    if (pend[d].lw_ok) e_lmd[d] = pend[d].lmd;
                    pend_v[d]  = 1'b0;
                end else begin
                    e_valid[d] = 0; e_taken[d] = 0; e_mis[d] = 0;
                end
                e_ready[d] = (cyc >= busy_until[d]);
                chk("valid_mem", d, 32'(o_valid[d]), 32'(e_valid[d]));
                chk("ready_ex", d, 32'(o_ready[d]), 32'(e_ready[d]));
                chk("IR_mem", d, o_ir[d], e_ir[d]);
                chk("ALU_out_mem", d, o_alu[d], e_alu[d]);
                chk("LMD", d, o_lmd[d], e_lmd[d]);
                chk("branch_taken", d, 32'(o_taken[d]), 32'(e_taken[d]));
                chk("branch_target", d, o_tgt[d], e_tgt[d]);
                chk("misalign", d, 32'(o_mis[d]), 32'(e_mis[d]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [31:0] ir, npc, alu, b, input logic cnd);
        int n = 0;
        @(negedge clk); #1;
        while (!ifa.ready_ex && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 40) chk("ready_timeout", 0, 32'(ifa.ready_ex), 32'd1);
        s_ir = ir; s_npc = npc; s_alu = alu; s_b = b; s_cond = cnd;
        s_valid  = 1'b1;
        last_acc = cyc + 1;
        model_issue(0, last_acc, ir, npc, alu, b, cnd);
        model_issue(1, last_acc, ir, npc, alu, b, cnd);
        last_due = pend[0].due;
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_ir  = $urandom; s_npc = $urandom; s_alu = $urandom; s_b = $urandom;
        s_cond = 1'($urandom_range(0, 1));
    endtask

    // Advance to the negedge where dut_a's last instruction is visible
    task automatic wait_done(output int stall);
        int n = 0;
        stall = 0;
        do begin
            @(negedge clk);
            if (!ifa.ready_ex) stall++;
            n++;
        end while (cyc < last_due && n < 50);
        if (n >= 50) chk("done_timeout", 0, 32'(cyc), 32'(last_due));
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1;
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 0, 32'(o_valid[0]), 32'd0);
        chk("rst_ready", 0, 32'(o_ready[0]), 32'd1);
        chk("rst_lmd", 0, o_lmd[0], 32'd0);
        chk("rst_ir", 0, o_ir[0], 32'd0);
        #1 rst = 1'b0;
    endtask

    initial begin
        int st;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < int'(DEPTH); i++) mram[d][i] = '0;
            pend_v[d] = 0; busy_until[d] = 0;
            e_valid[d] = 0; e_taken[d] = 0; e_mis[d] = 0; e_ready[d] = 1;
            e_ir[d] = '0; e_alu[d] = '0; e_lmd[d] = '0; e_tgt[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
        go  = 1'b1;

        // RR passes straight through on both instances
        issue(32'h00000000, 32'h4, 32'h8, 32'h0, 1'b0);
        wait_done(st);
        chk("rr_valid_b", 1, 32'(o_valid[1]), 32'd1);
        chk("rr_alu_b", 1, o_alu[1], 32'h8);
        chk("rr_nostall", 0, 32'(st), 32'd0);
        issue(32'h40000000, 32'h8, 32'h55, 32'h0, 1'b0);
        issue(32'h04000001, 32'hc, 32'h77, 32'h0, 1'b1);

        // SW with wait states, then LW of the same word
        issue(32'hc4000000, 32'h10, 32'h10, 32'hdeadbeef, 1'b0);
        wait_done(st);
        chk("sw_stall", 0, 32'(st), 32'd2);
        chk("sw_latency", 0, 32'(cyc - last_acc), 32'd2);
        chk("sw_valid", 0, 32'(o_valid[0]), 32'd1);
        issue(32'hc0000000, 32'h14, 32'h10, 32'h0, 1'b0);
        wait_done(st);
        chk("lw_lmd_a", 0, o_lmd[0], 32'hdeadbeef);
        chk("lw_lmd_b", 1, o_lmd[1], 32'hdeadbeef);

        // Branch resolution
        issue(32'hd4000000, 32'h200, 32'h120, 32'h0, 1'b1);
        wait_done(st);
        chk("beqz_taken", 0, 32'(o_taken[0]), 32'd1);
        chk("beqz_target", 0, o_tgt[0], 32'h120);
        issue(32'hd0000000, 32'h104, 32'h300, 32'h0, 1'b1);
        wait_done(st);
        chk("bneqz_taken", 0, 32'(o_taken[0]), 32'd0);
        chk("bneqz_target", 0, o_tgt[0], 32'h104);
        issue(32'hd0000000, 32'h108, 32'h400, 32'h0, 1'b0);
        issue(32'hfc000000, 32'h10c, 32'h44, 32'h0, 1'b0);
        repeat (3) @(negedge clk);

        // Address wrap modulo DEPTH
        issue(32'hc4000000, 32'h20, DEPTH * 4 + 4, 32'h12345678, 1'b0);
        issue(32'hc0000000, 32'h24, 32'h4, 32'h0, 1'b0);
        wait_done(st);
        chk("wrap_lmd", 0, o_lmd[0], 32'h12345678);
        issue(32'hc0000000, 32'h28, 32'h11, 32'h0, 1'b0);
        issue(32'h00000000, 32'h2c, 32'h9, 32'h0, 1'b0);

        // Reset during the wait of a SW drops the store
        issue(32'hc4000000, 32'h30, 32'h20, 32'h0, 1'b0);
        issue(32'hc4000000, 32'h34, 32'h20, 32'hcafef00d, 1'b0);
        do_reset();
        issue(32'hc0000000, 32'h38, 32'h20, 32'h0, 1'b0);
        wait_done(st);
        chk("abort_lmd_a", 0, o_lmd[0], 32'h0);
        chk("abort_lmd_b", 1, o_lmd[1], 32'hcafef00d);

`ifdef MEM_ALIGN_CHECK_EN
        issue(32'hc4000000, 32'h40, 32'h22, 32'haaaa5555, 1'b0);
        wait_done(st);
        chk("mis_flag", 0, 32'(o_mis[0]), 32'd1);
        chk("mis_nostall", 0, 32'(st), 32'd0);
        issue(32'hc0000000, 32'h44, 32'h20, 32'h0, 1'b0);
        wait_done(st);
        chk("mis_ram", 0, o_lmd[0], 32'h0);
`endif
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
